// File: rtl/dma_pkg.sv
// Shared DMA helpers: byte-enable popcount, lane-compaction prefix index and
// buffer sizing constants used by the realignment buffer.
package dma_pkg;

    // Widest beat supported is 512 bits, i.e. 64 byte lanes.
    localparam int DMA_MAX_LANES     = 64;
    localparam int DMA_LANE_IDX_WD   = 7;
    // Smallest useful realignment buffer: two beats of the narrowest (16-bit) bus... rounded up.
    localparam int DMA_MIN_BUF_BYTES = 8;

    // Number of enabled lanes in a byte-enable vector.
    function automatic logic [DMA_LANE_IDX_WD-1:0] dma_popcount(
        input logic [DMA_MAX_LANES-1:0] be
    );
        logic [DMA_LANE_IDX_WD-1:0] cnt;
        cnt = '0;
        for (int j = 0; j < DMA_MAX_LANES; j++) begin
            cnt = cnt + {{(DMA_LANE_IDX_WD-1){1'b0}}, be[j]};
        end
        return cnt;
    endfunction

    // Compacted position of a lane: how many enabled lanes sit below it.
    function automatic logic [DMA_LANE_IDX_WD-1:0] dma_prefix(
        input logic [DMA_MAX_LANES-1:0] be,
        input int                       lane
    );
        logic [DMA_LANE_IDX_WD-1:0] cnt;
        cnt = '0;
        for (int j = 0; j < DMA_MAX_LANES; j++) begin
            if (j < lane) begin
                cnt = cnt + {{(DMA_LANE_IDX_WD-1){1'b0}}, be[j]};
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dma_lane_pack.sv
// Combinational lane compactor: for each byte lane, the slot offset it maps
// to when only enabled lanes are kept in ascending order, plus the total count.
module dma_lane_pack
    import dma_pkg::*;
#(
    parameter int BE_WD  = 4,
    parameter int OFF_WD = $clog2(BE_WD) + 1
) (
    input  logic [BE_WD-1:0]             be_i,
    output logic [BE_WD-1:0][OFF_WD-1:0] off_o,
    output logic [OFF_WD-1:0]            cnt_o
);

    logic [DMA_MAX_LANES-1:0] be_ext;

    assign be_ext = DMA_MAX_LANES'(be_i);
    assign cnt_o  = OFF_WD'(dma_popcount(be_ext));

    // Per-lane prefix count gives each enabled lane its compacted slot.
    always_comb begin
        for (int i = 0; i < BE_WD; i++) begin
            off_o[i] = OFF_WD'(dma_prefix(be_ext, i));
        end
    end

endmodule

// File: rtl/dma_pack_buf.sv
// Byte-granular realignment buffer between the DMA read and write engines.
// Source beats are compacted into a circular byte store; destination beats
// gather the oldest bytes into whichever lanes they request.
module dma_pack_buf
    import dma_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int BE_WD   = DATA_WD / 8,
    parameter int DEPTH   = 64,
    parameter int CNT_WD  = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               flush_i,
    input  logic               wvalid_i,
    input  logic [DATA_WD-1:0] wdata_i,
    input  logic [BE_WD-1:0]   wbe_i,
    output logic               wready_o,
    output logic               rvalid_o,
    output logic [DATA_WD-1:0] rdata_o,
    input  logic [BE_WD-1:0]   rbe_i,
    input  logic               rready_i,
    output logic [CNT_WD-1:0]  level_o
);

    localparam int PTR_WD = $clog2(DEPTH);
    localparam int OFF_WD = $clog2(BE_WD) + 1;
    // A beat is accepted only if a full beat's worth of bytes is free.
    localparam logic [CNT_WD-1:0] WR_LIMIT = CNT_WD'(DEPTH - BE_WD);

    logic [7:0]              mem_q [DEPTH];
    logic [7:0]              mem_d [DEPTH];
    logic [PTR_WD-1:0]       wptr_q, wptr_d;
    logic [PTR_WD-1:0]       rptr_q, rptr_d;
    logic [CNT_WD-1:0]       level_q, level_d;

    logic [BE_WD-1:0][OFF_WD-1:0] woff;
    logic [BE_WD-1:0][OFF_WD-1:0] roff;
    logic [OFF_WD-1:0]            wcnt;
    logic [OFF_WD-1:0]            rcnt;
    logic                         push;
    logic                         pop;

    dma_lane_pack #(
        .BE_WD  (BE_WD),
        .OFF_WD (OFF_WD)
    ) u_wpack (
        .be_i   (wbe_i),
        .off_o  (woff),
        .cnt_o  (wcnt)
    );

    dma_lane_pack #(
        .BE_WD  (BE_WD),
        .OFF_WD (OFF_WD)
    ) u_rpack (
        .be_i   (rbe_i),
        .off_o  (roff),
        .cnt_o  (rcnt)
    );

    assign level_o  = level_q;
    assign wready_o = (level_q <= WR_LIMIT);
    // Eligibility uses the registered level only, so freshly pushed bytes wait a cycle.
    assign rvalid_o = (rcnt != '0) && (level_q >= CNT_WD'(rcnt));
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;

    // Gather the oldest bytes into the requested lanes; idle lanes read as zero.
    always_comb begin
        rdata_o = '0;
        if (rvalid_o) begin
            for (int i = 0; i < BE_WD; i++) begin
                if (rbe_i[i]) begin
                    rdata_o[i*8 +: 8] = mem_q[rptr_q + PTR_WD'(roff[i])];
                end
            end
        end
    end

    // Scatter enabled source lanes into consecutive slots from the write pointer.
    always_comb begin
        mem_d = mem_q;
        if (push && !flush_i) begin
            for (int i = 0; i < BE_WD; i++) begin
                if (wbe_i[i]) begin
                    mem_d[wptr_q + PTR_WD'(woff[i])] = wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Pointer and occupancy update; flush wins over any handshake in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_WD'(wcnt);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_WD'(rcnt);
            end
            level_d = level_q
                    + (push ? CNT_WD'(wcnt) : '0)
                    - (pop  ? CNT_WD'(rcnt) : '0);
        end
    end

    // Byte storage carries no reset; stale contents are never visible past level.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: tb/tb_dma_pack_buf.sv
// Testbench for dma_pack_buf: directed scenarios plus a randomized stream,
// checked against a byte-queue reference model.
module tb_dma_pack_buf;

    logic        clk_i;
    logic        rstn_i;
    logic        flush_i;
    logic        wvalid_i;
    logic [31:0] wdata_i;
    logic [3:0]  wbe_i;
    logic        wready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [3:0]  rbe_i;
    logic        rready_i;
    logic [6:0]  level_o;

    int checks;
    int errors;

    // Reference model: FIFO of bytes in arrival order.
    logic [7:0] q [$];

    dma_pack_buf dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .flush_i  (flush_i),
        .wvalid_i (wvalid_i),
        .wdata_i  (wdata_i),
        .wbe_i    (wbe_i),
        .wready_o (wready_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .rbe_i    (rbe_i),
        .rready_i (rready_i),
        .level_o  (level_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int popc(logic [3:0] be);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += int'(be[i]);
        return c;
    endfunction

    function automatic bit m_wready();
        return (64 - q.size()) >= 4;
    endfunction

    function automatic bit m_rvalid(logic [3:0] be);
        return (popc(be) != 0) && (q.size() >= popc(be));
    endfunction

    function automatic logic [31:0] m_rdata(logic [3:0] be);
        logic [31:0] d;
        int k;
        d = '0;
        k = 0;
        if (m_rvalid(be)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    d[i*8 +: 8] = q[k];
                    k++;
                end
            end
        end
        return d;
    endfunction

    task automatic set_in(bit wv, logic [31:0] wd, logic [3:0] wb,
                          logic [3:0] rb, bit rr, bit fl);
        wvalid_i = wv;
        wdata_i  = wd;
        wbe_i    = wb;
        rbe_i    = rb;
        rready_i = rr;
        flush_i  = fl;
        #1;
    endtask

    // Advance one clock and apply the same handshakes to the model.
    task automatic tick();
        bit push, pop;
        int n;
        n    = popc(rbe_i);
        push = wvalid_i && m_wready();
        pop  = rready_i && m_rvalid(rbe_i);
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
        end else begin
            if (pop) repeat (n) void'(q.pop_front());
            if (push) begin
                for (int i = 0; i < 4; i++)
                    if (wbe_i[i]) q.push_back(wdata_i[i*8 +: 8]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        #20;
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL reset_wready got=%b want=1", wready_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b want=0", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata_o); end
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", level_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        q.delete();
    endtask

    task automatic test_basic();
        set_in(1, 32'h44332211, 4'hF, 4'h3, 1, 0);
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL basic_empty_rvalid got=%b want=0", rvalid_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h3, 1, 0);
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL basic_rvalid got=%b want=1", rvalid_o); end
        checks++; if (rdata_o !== 32'h00002211) begin errors++; $display("FAIL basic_rdata_lo got=%h want=00002211", rdata_o); end
        checks++; if (level_o !== 7'd4) begin errors++; $display("FAIL basic_level4 got=%0d want=4", level_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'hC, 1, 0);
        checks++; if (level_o !== 7'd2) begin errors++; $display("FAIL basic_level2 got=%0d want=2", level_o); end
        checks++; if (rdata_o !== 32'h44330000) begin errors++; $display("FAIL basic_rdata_hi got=%h want=44330000", rdata_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL basic_level0 got=%0d want=0", level_o); end
    endtask

    task automatic test_partial_beats();
        set_in(1, 32'hDDCCBBAA, 4'hE, 4'h0, 0, 0);
        tick();
        set_in(1, 32'h000000EE, 4'h1, 4'h0, 0, 0);
        tick();
        set_in(0, 32'h0, 4'h0, 4'hF, 1, 0);
        checks++; if (rdata_o !== 32'hEEDDCCBB) begin errors++; $display("FAIL partial_rdata got=%h want=EEDDCCBB", rdata_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL partial_level got=%0d want=0", level_o); end
    endtask

    task automatic test_noncontig();
        set_in(1, 32'h44332211, 4'hA, 4'h0, 0, 0);
        tick();
        set_in(1, 32'h55555555, 4'h0, 4'h6, 1, 0);
        checks++; if (level_o !== 7'd2) begin errors++; $display("FAIL noncontig_level got=%0d want=2", level_o); end
        checks++; if (rdata_o !== 32'h00442200) begin errors++; $display("FAIL noncontig_rdata got=%h want=00442200", rdata_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL null_beat_level got=%0d want=0", level_o); end
    endtask

    task automatic test_full_wrap();
        int seq, cyc;
        logic [3:0] rb, wb;
        logic [31:0] wd;
        bit wv, rr, fire, popped;
        for (int b = 0; b < 15; b++) begin
            set_in(1, $urandom, 4'hF, 4'h0, 0, 0);
            tick();
        end
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        checks++; if (level_o !== 7'd60) begin errors++; $display("FAIL full_level60 got=%0d want=60", level_o); end
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL full_wready60 got=%b want=1", wready_o); end
        set_in(1, $urandom, 4'hF, 4'h0, 0, 0);
        tick();
        set_in(1, 32'hFFFFFFFF, 4'hF, 4'h1, 1, 0);
        checks++; if (level_o !== 7'd64) begin errors++; $display("FAIL full_level64 got=%0d want=64", level_o); end
        checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL full_wready64 got=%b want=0", wready_o); end
        checks++; if (rdata_o !== m_rdata(4'h1)) begin errors++; $display("FAIL full_pop1_rdata got=%h want=%h", rdata_o, m_rdata(4'h1)); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h7, 1, 0);
        checks++; if (level_o !== 7'd63) begin errors++; $display("FAIL full_level63 got=%0d want=63", level_o); end
        checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL full_wready63 got=%b want=0", wready_o); end
        checks++; if (rdata_o !== m_rdata(4'h7)) begin errors++; $display("FAIL full_pop3_rdata got=%h want=%h", rdata_o, m_rdata(4'h7)); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        checks++; if (level_o !== 7'd60) begin errors++; $display("FAIL full_level60b got=%0d want=60", level_o); end
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL full_wready60b got=%b want=1", wready_o); end

        // Random stream of 200 incrementing bytes with back-pressure on both sides.
        seq = 0;
        cyc = 0;
        rb = 4'($urandom_range(1, 15));
        popped = 1'b1;
        rr = 1'b0;
        while (!(seq >= 200 && q.size() == 0) && cyc < 5000) begin
            // Destination keeps its request stable while waiting, except when
            // the tail of the stream can never satisfy it.
            if (popped || !rr || (seq >= 200 && q.size() < popc(rb)))
                rb = 4'($urandom_range(1, 15));
            rr = ($urandom_range(0, 3) != 0);
            wv = (seq < 200) && ($urandom_range(0, 2) != 0);
            wb = 4'($urandom);
            wd = $urandom;
            fire = wv && m_wready();
            if (fire) begin
                for (int i = 0; i < 4; i++) begin
                    if (wb[i] && seq < 200) begin
                        wd[i*8 +: 8] = 8'(seq);
                        seq++;
                    end else if (wb[i]) begin
                        wb[i] = 1'b0;
                    end
                end
            end
            set_in(wv, wd, wb, rb, rr, 0);
            checks++;
            if (rvalid_o !== m_rvalid(rb) || rdata_o !== m_rdata(rb)) begin
                errors++;
                $display("FAIL stream_read cyc=%0d got=%b/%h want=%b/%h", cyc, rvalid_o, rdata_o, m_rvalid(rb), m_rdata(rb));
            end
            checks++;
            if (level_o !== 7'(q.size()) || wready_o !== m_wready()) begin
                errors++;
                $display("FAIL stream_level cyc=%0d got=%0d/%b want=%0d/%b", cyc, level_o, wready_o, q.size(), m_wready());
            end
            popped = rr && m_rvalid(rb);
            tick();
            cyc++;
        end
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        checks++; if (cyc >= 5000) begin errors++; $display("FAIL stream_timeout got=%0d cycles want=<5000", cyc); end
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL stream_drained got=%0d want=0", level_o); end
    endtask

    task automatic test_same_cycle();
        set_in(1, 32'h0A0B0C0D, 4'hF, 4'h1, 1, 0);
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL same_nobypass got=%b want=0", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL same_rdata_zero got=%h want=0", rdata_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'h3, 1, 0);
        checks++; if (level_o !== 7'd4) begin errors++; $display("FAIL same_level4 got=%0d want=4", level_o); end
        tick();
        set_in(1, 32'h14131211, 4'hF, 4'h3, 1, 0);
        checks++; if (level_o !== 7'd2) begin errors++; $display("FAIL same_level2 got=%0d want=2", level_o); end
        checks++; if (rdata_o !== 32'h00000A0B) begin errors++; $display("FAIL same_pushpop_rdata got=%h want=00000A0B", rdata_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'hF, 1, 0);
        checks++; if (level_o !== 7'd4) begin errors++; $display("FAIL same_pushpop_level got=%0d want=4", level_o); end
        checks++; if (rdata_o !== 32'h14131211) begin errors++; $display("FAIL same_order_rdata got=%h want=14131211", rdata_o); end
        tick();
    endtask

    task automatic fill_ten();
        set_in(1, $urandom, 4'hF, 4'h0, 0, 0); tick();
        set_in(1, $urandom, 4'hF, 4'h0, 0, 0); tick();
        set_in(1, $urandom, 4'h3, 4'h0, 0, 0); tick();
    endtask

    task automatic test_flush();
        fill_ten();
        set_in(1, 32'hCAFEF00D, 4'hF, 4'hF, 1, 1);
        checks++; if (level_o !== 7'd10) begin errors++; $display("FAIL flush_pre_level got=%0d want=10", level_o); end
        tick();
        set_in(0, 32'h0, 4'h0, 4'hF, 1, 0);
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL flush_level got=%0d want=0", level_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL flush_rvalid got=%b want=0", rvalid_o); end
        set_in(1, 32'h04030201, 4'hF, 4'h0, 0, 0);
        tick();
        set_in(0, 32'h0, 4'h0, 4'hF, 1, 0);
        checks++; if (rdata_o !== 32'h04030201) begin errors++; $display("FAIL flush_restart_rdata got=%h want=04030201", rdata_o); end
        tick();
    endtask

    task automatic test_async_reset();
        set_in(0, 32'h0, 4'h0, 4'h0, 0, 0);
        fill_ten();
        set_in(0, 32'h0, 4'h0, 4'h1, 0, 0);
        checks++; if (level_o !== 7'd10) begin errors++; $display("FAIL areset_pre_level got=%0d want=10", level_o); end
        #2;
        rstn_i = 1'b0;
        #1;
        q.delete();
        checks++; if (level_o !== 7'd0) begin errors++; $display("FAIL areset_level got=%0d want=0", level_o); end
        checks++; if (wready_o !== 1'b1) begin errors++; $display("FAIL areset_wready got=%b want=1", wready_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL areset_rvalid got=%b want=0", rvalid_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_partial_beats();
        test_noncontig();
        test_full_wrap();
        test_same_cycle();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
